// File: rtl/cavlc_bit_window.sv
// Bitstream window for the CAVLC coeff_token decoder: buffers up to 64 bits of
// MSB-first slice data and presents the oldest 16 unconsumed bits, left-aligned.
module cavlc_bit_window #(
  parameter int IN_WIDTH  = 32,
  parameter int WIN_WIDTH = 16,
  parameter int BUF_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIN_WIDTH-1:0] bits,
  output logic                 bits_valid,
  input  logic                 consume,
  input  logic [4:0]           num_shift,
  output logic [6:0]           level,
  output logic [31:0]          bit_pos,
  output logic                 shift_err
);

  localparam logic [6:0] IN_BITS  = 7'(IN_WIDTH);
  localparam logic [6:0] WIN_BITS = 7'(WIN_WIDTH);

  // Handshake: a word transfers on any edge where in_valid & in_ready are both
  // high; in_ready is derived only from the registered level (plus flush), so
  // the producer never sees a combinational path from consume.

  logic [BUF_WIDTH-1:0] buf_q;
  logic [6:0]           level_q;
  logic [31:0]          bit_pos_q;
  logic                 shift_err_q;

  logic                 consume_ok;
  logic                 consume_bad;
  logic                 load;
  logic [6:0]           shift_amt;
  logic [6:0]           level_after;
  logic [BUF_WIDTH-1:0] shifted;
  logic [BUF_WIDTH-1:0] appended;
  logic [BUF_WIDTH-1:0] buf_next;
  logic [6:0]           level_next;

  assign bits       = buf_q[BUF_WIDTH-1 -: WIN_WIDTH];
  assign bits_valid = (level_q >= WIN_BITS);
  assign in_ready   = (level_q <= (7'(BUF_WIDTH) - IN_BITS)) & ~flush;
  assign level      = level_q;
  assign bit_pos    = bit_pos_q;
  assign shift_err  = shift_err_q;

  always_comb begin
    consume_ok  = consume & bits_valid & (num_shift != 5'd0) & (num_shift <= 5'(WIN_WIDTH));
    consume_bad = consume & ~consume_ok;
    load        = in_valid & in_ready;
    shift_amt   = consume_ok ? {2'b00, num_shift} : 7'd0;
    level_after = level_q - shift_amt;
    shifted     = buf_q << shift_amt;
    // The new word lands right after whatever survives this cycle's shift,
    // so the zero region below the valid bits stays zero.
    appended    = {in_data, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> level_after;
    buf_next    = load ? (shifted | appended) : shifted;
    level_next  = load ? (level_after + IN_BITS) : level_after;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      level_q     <= '0;
      bit_pos_q   <= '0;
      shift_err_q <= 1'b0;
    end else if (flush) begin
      buf_q       <= '0;
      level_q     <= '0;
      bit_pos_q   <= '0;
      shift_err_q <= 1'b0;
    end else begin
      buf_q     <= buf_next;
      level_q   <= level_next;
      bit_pos_q <= bit_pos_q + {25'd0, shift_amt};
      if (consume_bad) shift_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cavlc_bit_window.sv
// Directed and randomized checks of cavlc_bit_window against hand-computed
// values and a bit-queue reference model.
module tb_cavlc_bit_window;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bits;
  logic        bits_valid;
  logic        consume;
  logic [4:0]  num_shift;
  logic [6:0]  level;
  logic [31:0] bit_pos;
  logic        shift_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0]  exp_q[$];
  logic [31:0] exp_pos;

  cavlc_bit_window dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bits       (bits),
    .bits_valid (bits_valid),
    .consume    (consume),
    .num_shift  (num_shift),
    .level      (level),
    .bit_pos    (bit_pos),
    .shift_err  (shift_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; consume = 1'b0; num_shift = 5'd0; in_data = '0;
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    idle(); in_data = w; in_valid = 1'b1; step(); in_valid = 1'b0;
  endtask

  task automatic do_consume(input logic [4:0] n);
    idle(); consume = 1'b1; num_shift = n; step(); consume = 1'b0;
  endtask

  function automatic logic [15:0] model_bits();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      if (i < exp_q.size()) w[15-i] = exp_q[i];
    return w;
  endfunction

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_level", level, 0);
    check("rst_bits", bits, 0);
    check("rst_bits_valid", bits_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bit_pos", bit_pos, 0);
    check("rst_shift_err", shift_err, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;

    // first load right after reset
    load_word(32'hDEADBEEF);
    check("load1_level", level, 32);
    check("load1_bits", bits, 16'hDEAD);
    check("load1_valid", bits_valid, 1);
    check("load1_ready", in_ready, 1);
    do_consume(5'd4);
    check("c4_bits", bits, 16'hEADB);
    check("c4_level", level, 28);
    check("c4_pos", bit_pos, 4);
    do_consume(5'd16);
    check("c16_bits", bits, 16'hEEF0);
    check("c16_level", level, 12);
    check("c16_valid", bits_valid, 0);
    check("c16_pos", bit_pos, 20);

    // simultaneous load and consume
    do_flush();
    check("flush_level", level, 0);
    check("flush_pos", bit_pos, 0);
    load_word(32'hFFFABCDE);
    do_consume(5'd12);
    check("pre_lc_level", level, 20);
    check("pre_lc_bits", bits, 16'hABCD);
    idle(); in_data = 32'h12345678; in_valid = 1'b1; consume = 1'b1; num_shift = 5'd8;
    step(); idle();
    check("lc_level", level, 44);
    check("lc_bits", bits, 16'hCDE1);
    do_consume(5'd16);
    check("lc_tail_bits", bits, 16'h2345);
    check("lc_tail_level", level, 28);
    check("lc_tail_pos", bit_pos, 36);

    // fill to 64 with in_valid held
    do_flush();
    idle(); in_valid = 1'b1; in_data = 32'h11111111; step();
    in_data = 32'h22222222; step();
    check("full_level", level, 64);
    check("full_ready", in_ready, 0);
    in_data = 32'h33333333; step();
    check("held_level", level, 64);
    check("held_bits", bits, 16'h1111);
    consume = 1'b1; num_shift = 5'd16; step();
    check("full_c1_level", level, 48);
    check("full_c1_ready", in_ready, 0);
    step();
    consume = 1'b0; in_valid = 1'b0;
    check("full_c2_level", level, 32);
    check("full_c2_bits", bits, 16'h2222);
    check("full_c2_ready", in_ready, 1);

    // illegal consumes
    do_flush();
    load_word(32'hA5A5A5A5);
    do_consume(5'd16);
    do_consume(5'd8);
    check("lvl8_level", level, 8);
    do_consume(5'd4);
    check("ill_lvl_level", level, 8);
    check("ill_lvl_pos", bit_pos, 24);
    check("ill_lvl_err", shift_err, 1);
    do_flush();
    check("err_clr", shift_err, 0);
    check("err_clr_level", level, 0);
    load_word(32'h0F0F0F0F);
    do_consume(5'd0);
    check("ill_zero_level", level, 32);
    check("ill_zero_pos", bit_pos, 0);
    check("ill_zero_err", shift_err, 1);
    do_flush();
    load_word(32'h0F0F0F0F);
    do_consume(5'd17);
    check("ill_17_level", level, 32);
    check("ill_17_bits", bits, 16'h0F0F);
    check("ill_17_err", shift_err, 1);
    idle(); flush = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D; step(); idle();
    check("flush_load_level", level, 0);
    check("flush_load_bits", bits, 0);
    check("flush_load_err", shift_err, 0);

    // asynchronous reset mid-stream
    load_word(32'h01234567);
    load_word(32'h89ABCDEF);
    do_consume(5'd16);
    do_consume(5'd8);
    check("pre_arst_level", level, 40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_bits", bits, 0);
    check("arst_pos", bit_pos, 0);
    check("arst_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    step();

    // random stream against the bit-queue model
    exp_q.delete();
    exp_pos = '0;
    for (int c = 0; c < 300; c++) begin
      logic       iv;
      logic       cs;
      logic [4:0] ns;
      logic [31:0] w;
      int         sz;
      idle();
      sz = exp_q.size();
      iv = 1'($urandom_range(0, 1));
      cs = (sz >= 16) && ($urandom_range(0, 2) != 0);
      ns = 5'($urandom_range(1, 16));
      w  = $urandom;
      in_valid = iv; in_data = w; consume = cs; num_shift = ns;
      if (cs) begin
        for (int k = 0; k < ns; k++) void'(exp_q.pop_front());
        exp_pos = exp_pos + 32'(ns);
      end
      if (iv && sz <= 32)
        for (int k = 31; k >= 0; k--) exp_q.push_back(w[k]);
      step();
      check("rnd_bits", bits, model_bits());
      check("rnd_level", level, exp_q.size());
      check("rnd_pos", bit_pos, exp_pos);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cavlc_bit_window.md
Name: cavlc_bit_window

Overview:
- Bitstream front-end for the CAVLC coeff_token decode path.
- Accepts 32-bit MSB-first slice-data words, buffers up to 64 bits, and presents a left-aligned 16-bit window to the coeff_token lookup tables.
- Advances the window by the table's NumShift (1..16 bits) once per accepted consume.
- Sits directly upstream of the coeff_token LUTs: its Bits output drives their Bits input, and their NumShift output returns here.

Parameters:
- IN_WIDTH, 32, input word width in bits.
- WIN_WIDTH, 16, output window width in bits.
- BUF_WIDTH, 64, internal buffer depth in bits; must equal 2*IN_WIDTH.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous clear of all buffered bits.
- InData  in  32  next bitstream word; bit 31 is the first bit in stream order.
- InValid  in  1  InData valid.
- InReady  out  1  block can accept InData this cycle.
- Bits  out  16  window; Bits[15] is the oldest unconsumed bit.
- BitsValid  out  1  at least 16 valid bits are buffered.
- Consume  in  1  request to advance the window by NumShift.
- NumShift  in  5  shift amount; legal range 1..16.
- Level  out  7  count of valid buffered bits, 0..64.
- BitPos  out  32  total bits consumed since reset or Flush; wraps modulo 2^32.
- ShiftErr  out  1  sticky illegal-consume flag.

Behaviour:
- Reset (Rst_n low, async): buffer=0, Level=0, BitPos=0, ShiftErr=0. Consequently BitsValid=0, InReady=1, Bits=0.
- Storage: 64-bit register Buf, left-aligned. Valid bits occupy Buf[63:64-Level]. Every bit below the valid region is held at 0 (invariant).
- Outputs:
  - Bits = Buf[63:48], purely from registers.
  - BitsValid = (Level>=16).
  - InReady = (Level<=32) & ~Flush. Depends on registered Level only; no combinational path from Consume.
- Accepted consume: Consume & BitsValid & (1<=NumShift<=16). On the next edge, Buf shifts left by NumShift with zero fill, Level -= NumShift, BitPos += NumShift. New Bits appear the cycle after Consume (1-cycle latency). Back-to-back consumes every cycle are legal.
- Illegal consume: Consume with BitsValid=0, NumShift=0, or NumShift>16. State is unchanged and ShiftErr is set. ShiftErr clears only on reset or Flush.
- Load: InValid & InReady. The word is written at bit offset (Level - accepted shift) from the MSB, i.e. after that cycle's shift. Level increases by 32.
- Simultaneous load + consume: both apply in the same edge, shift first then append. Level_next = Level - NumShift + 32. This never exceeds 64 because InReady requires Level<=32.
- Flush: takes priority over load and consume in the same cycle. Buf=0, Level=0, BitPos=0, ShiftErr=0 next cycle. InData is not accepted in the Flush cycle.
- Level=64: InReady=0. Consumes are still accepted.
- Level 1..15: BitsValid=0. Bits shows the partial valid bits followed by zeros, but the downstream stage must not consume.
- BitPos at 0xFFFFFFFF + n wraps to n-1 with no flag.
- Reset asserted mid-operation clears everything immediately. After Rst_n deasserts, the first load is accepted on the first edge with InValid=1.

Test Plan:
- Reset then InData=0xDEADBEEF with InValid=1 for one cycle -> next cycle Level=32, Bits=0xDEAD, BitsValid=1, InReady=1.
- From that state, Consume with NumShift=4 -> next cycle Bits=0xEADB, Level=28, BitPos=4. Then NumShift=16 -> Bits=0xEEF0, Level=12, BitsValid=0.
- Level=20 with Buf=0xABCDE..., simultaneous load 0x12345678 and Consume NumShift=8 -> next cycle Level=44, Bits=0xCDE1, and the appended word starts at bit 51.
- Fill to Level=64 (two loads from empty, with InValid held) -> InReady=0 and a third word is held off. Consume NumShift=16 twice -> InReady=1 once Level=32.
- Consume with Level=8, or with NumShift=0 or 17 -> Level/BitPos unchanged, ShiftErr=1. A following Flush -> ShiftErr=0, Level=0. Flush together with InValid=1 -> word not accepted.
- Assert Rst_n low asynchronously mid-stream at Level=40 -> outputs reach reset values without a clock edge. Random stream of loads plus legal NumShift values vs a reference bit-queue model -> Bits/Level/BitPos match every cycle.
